// File: rtl/encode_if.sv
// encode_if: field-bundle input and encoded-word output handshakes of the RV32I encoder
// slave modport is the encoder view, master modport is the producer/consumer view.
// i_valid/o_ready carry a decoded field bundle in; o_valid/i_ready carry the encoded word out.
interface encode_if #(
  parameter int COUNT_W = 16
);
  logic               i_valid;
  logic               o_ready;
  logic [6:0]         i_opcode;
  logic [7:0]         i_funct7;
  logic [2:0]         i_funct3;
  logic [4:0]         i_rs1;
  logic [4:0]         i_rs2;
  logic [4:0]         i_rd;
  logic [31:0]        i_imm;
  logic [2:0]         i_inst_type;
  logic               o_valid;
  logic               i_ready;
  logic [31:0]        o_instruction;
  logic               o_err;
  logic [COUNT_W-1:0] o_count;
  modport slave (
    input  i_valid, i_opcode, i_funct7, i_funct3, i_rs1, i_rs2, i_rd, i_imm, i_inst_type, i_ready,
    output o_ready, o_valid, o_instruction, o_err, o_count
  );
  modport master (
    output i_valid, i_opcode, i_funct7, i_funct3, i_rs1, i_rs2, i_rd, i_imm, i_inst_type, i_ready,
    input  o_ready, o_valid, o_instruction, o_err, o_count
  );
endinterface

// File: rtl/encode.sv
// encode: packs decoded RV32I fields back into a 32-bit instruction word, buffered in an output FIFO
// Ports: clk; rst (sync, active-high, beats clk_en); clk_en (global advance, gates both handshakes);
//   bus (encode_if.slave): field bundle in via i_valid/o_ready, word out via o_valid/i_ready
//   with o_instruction/o_err showing the FIFO head (0 when empty), o_count = bundles accepted.
// Optional: define ENCODE_RANGE_CHECK_EN to also flag out-of-field immediate/funct7 bits as errors.
module encode #(
  parameter int FIFO_DEPTH = 2,
  parameter int COUNT_W    = 16
) (
  input logic     clk,
  input logic     rst,
  input logic     clk_en,
  encode_if.slave bus
);
  typedef enum logic [2:0] {T_ERROR, T_R, T_I, T_S, T_B, T_U, T_J, T_UNDEF} inst_type_e;
  localparam int PW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  inst_type_e   w_type;
  logic [6:0]   w_op;
  logic [31:0]  w_imm;
  logic [31:0]  w_word;
  logic         w_type_ok;
  logic         w_range_err;
  logic         w_err;
  logic         w_push;
  logic         w_pop;
  logic [32:0]  w_head;
  logic [32:0]  r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_rd;
  logic [PW-1:0] r_wr;
  logic [CW-1:0] r_cnt;
  logic [COUNT_W-1:0] r_count;
  assign w_type = inst_type_e'(bus.i_inst_type);
  assign w_op   = bus.i_opcode;
  assign w_imm  = bus.i_imm;
  always_comb begin
    w_word    = 32'h0;
    w_type_ok = 1'b0;
    case (w_type)
      T_R: begin
        w_word    = {bus.i_funct7[6:0], bus.i_rs2, bus.i_rs1, bus.i_funct3, bus.i_rd, w_op};
        w_type_ok = w_op == 7'b0110011;
      end
      T_I: begin
        w_word    = {w_imm[11:0], bus.i_rs1, bus.i_funct3, bus.i_rd, w_op};
        w_type_ok = w_op inside {7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011};
      end
      T_S: begin
        w_word    = {w_imm[11:5], bus.i_rs2, bus.i_rs1, bus.i_funct3, w_imm[4:0], w_op};
        w_type_ok = w_op == 7'b0100011;
      end
      T_B: begin
        w_word    = {w_imm[12], w_imm[10:5], bus.i_rs2, bus.i_rs1, bus.i_funct3, w_imm[4:1], w_imm[11], w_op};
        w_type_ok = w_op == 7'b1100011;
      end
      T_U: begin
        w_word    = {w_imm[31:12], bus.i_rd, w_op};
        w_type_ok = w_op inside {7'b0110111, 7'b0010111};
      end
      T_J: begin
        w_word    = {w_imm[20], w_imm[10:1], w_imm[11], w_imm[19:12], bus.i_rd, w_op};
        w_type_ok = w_op == 7'b1101111;
      end
      default: w_type_ok = 1'b0;
    endcase
  end
`ifdef ENCODE_RANGE_CHECK_EN
  always_comb begin
    w_range_err = 1'b0;
    case (w_type)
      T_R:      w_range_err = bus.i_funct7[7];
      T_I, T_S: w_range_err = |w_imm[31:12];
      T_B:      w_range_err = w_imm[0] | (|w_imm[31:13]);
      T_U:      w_range_err = |w_imm[11:0];
      T_J:      w_range_err = w_imm[0] | (|w_imm[31:21]);
      default:  w_range_err = 1'b0;
    endcase
  end
`else
  logic w_unused;
  assign w_unused    = bus.i_funct7[7];
  assign w_range_err = 1'b0;
`endif
  assign w_err = !w_type_ok | w_range_err;
  // Handshakes are gated by clk_en, so push/pop alone decide every state change.
  assign bus.o_ready = clk_en & (r_cnt < CW'(FIFO_DEPTH));
  assign bus.o_valid = clk_en & (r_cnt != '0);
  assign w_push = bus.i_valid & bus.o_ready;
  assign w_pop  = bus.o_valid & bus.i_ready;
  assign w_head = r_cnt != '0 ? r_mem[r_rd] : 33'h0;
  assign bus.o_instruction = w_head[31:0];
  assign bus.o_err   = w_head[32];
  assign bus.o_count = r_count;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(FIFO_DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_cnt   <= '0;
      r_count <= '0;
    end else begin
      r_rd    <= w_pop ? nxt(r_rd) : r_rd;
      r_wr    <= w_push ? nxt(r_wr) : r_wr;
      r_cnt   <= r_cnt + CW'(w_push) - CW'(w_pop);
      r_count <= r_count + COUNT_W'(w_push);
    end
  end
  // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (!rst && w_push) r_mem[r_wr] <= {w_err, w_err ? 32'h0 : w_word};
  end
endmodule

// File: tb/tb_encode.sv
// tb_encode: randomized round-trip and directed checks of the RV32I encoder against a decode-side model
module tb_encode;
  localparam int DEPTH = 2;
  typedef struct {
    logic [2:0]  t;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [7:0]  f7;
    logic [31:0] imm;
  } bundle_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clk_en = 1'b1;
  int n_tests = 0;
  int n_fail = 0;
  logic [15:0] exp_count = 16'h0;
  encode_if #(.COUNT_W(16)) bus ();
  encode #(.FIFO_DEPTH(DEPTH), .COUNT_W(16)) dut (.clk(clk), .rst(rst), .clk_en(clk_en), .bus(bus));
  always #5 clk = ~clk;

  function automatic bundle_t mk(input logic [2:0] t, input logic [6:0] op, input logic [4:0] rd,
                                 input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                                 input logic [7:0] f7, input logic [31:0] imm);
    bundle_t b;
    b.t = t; b.op = op; b.rd = rd; b.rs1 = rs1; b.rs2 = rs2; b.f3 = f3; b.f7 = f7; b.imm = imm;
    return b;
  endfunction

  // Reference model: a decoder. Decoding a legal word and re-encoding it must reproduce the word.
  function automatic bundle_t decode(input logic [31:0] w, input logic [2:0] t);
    bundle_t b;
    b = mk(t, w[6:0], w[11:7], w[19:15], w[24:20], w[14:12], {1'b0, w[31:25]}, 32'h0);
    case (t)
      3'd2: b.imm = {20'h0, w[31:20]};
      3'd3: b.imm = {20'h0, w[31:25], w[11:7]};
      3'd4: b.imm = {19'h0, w[31], w[7], w[30:25], w[11:8], 1'b0};
      3'd5: b.imm = {w[31:12], 12'h0};
      3'd6: b.imm = {11'h0, w[31], w[19:12], w[20], w[30:21], 1'b0};
      default: b.imm = 32'h0;
    endcase
    return b;
  endfunction

  function automatic logic [6:0] legal_op(input logic [2:0] t, input int unsigned k);
    case (t)
      3'd1: return 7'h33;
      3'd2: return k % 4 == 0 ? 7'h13 : k % 4 == 1 ? 7'h03 : k % 4 == 2 ? 7'h67 : 7'h73;
      3'd3: return 7'h23;
      3'd4: return 7'h63;
      3'd5: return k % 2 == 0 ? 7'h37 : 7'h17;
      default: return 7'h6F;
    endcase
  endfunction

  task automatic drive(input bundle_t b, input logic v, input logic r);
    bus.i_inst_type = b.t; bus.i_opcode = b.op; bus.i_rd = b.rd; bus.i_rs1 = b.rs1;
    bus.i_rs2 = b.rs2; bus.i_funct3 = b.f3; bus.i_funct7 = b.f7; bus.i_imm = b.imm;
    bus.i_valid = v; bus.i_ready = r;
  endtask

  task automatic gen(output bundle_t b, output logic [32:0] exp);
    int unsigned r;
    logic [31:0] w;
    logic [2:0] t;
    r = $urandom_range(0, 11);
    w = $urandom;
    t = 3'($urandom_range(1, 6));
    if (r < 9) begin
      w[6:0] = legal_op(t, $urandom);
      b = decode(w, t);
      if (t != 3'd1) b.f7 = 8'($urandom);
      if (t == 3'd1) b.imm = $urandom;
      if (t == 3'd3 || t == 3'd4) b.rd = 5'($urandom);
      if (t >= 3'd5) begin b.rs1 = 5'($urandom); b.rs2 = 5'($urandom); b.f3 = 3'($urandom); end
      if (t == 3'd2) b.rs2 = 5'($urandom);
      exp = {1'b0, w};
    end else if (r == 9) begin
      b = decode(w, $urandom_range(0, 1) == 0 ? 3'd0 : 3'd7);
      exp = {1'b1, 32'h0};
    end else begin
      w[6:0] = 7'h0B;
      b = decode(w, t);
      exp = {1'b1, 32'h0};
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    clk_en = 1'b1;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0), 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_o_valid got %b want 0", bus.o_valid); end
    n_tests++; if (bus.o_instruction !== 32'h0) begin n_fail++; $display("FAIL reset_o_instruction got %h want 0", bus.o_instruction); end
    n_tests++; if (bus.o_err !== 1'b0) begin n_fail++; $display("FAIL reset_o_err got %b want 0", bus.o_err); end
    n_tests++; if (bus.o_count !== 16'h0) begin n_fail++; $display("FAIL reset_o_count got %0d want 0", bus.o_count); end
    rst = 1'b0;
    exp_count = 16'h0;
    #1;
    n_tests++; if (bus.o_ready !== 1'b1) begin n_fail++; $display("FAIL reset_o_ready got %b want 1", bus.o_ready); end
  endtask

  task automatic test_vectors;
    bundle_t v[9];
    logic [32:0] e[9];
    v[0] = mk(1, 7'h33, 3, 1, 2, 0, 0, 0);              e[0] = {1'b0, 32'h002081B3};
    v[1] = mk(2, 7'h13, 1, 0, 0, 0, 0, 5);              e[1] = {1'b0, 32'h00500093};
    v[2] = mk(3, 7'h23, 0, 1, 2, 2, 0, 8);              e[2] = {1'b0, 32'h0020A423};
    v[3] = mk(4, 7'h63, 0, 1, 2, 0, 0, 16);             e[3] = {1'b0, 32'h00208863};
    v[4] = mk(6, 7'h6F, 1, 0, 0, 0, 0, 32'h800);        e[4] = {1'b0, 32'h001000EF};
    v[5] = mk(5, 7'h37, 5, 0, 0, 0, 0, 32'h12345000);   e[5] = {1'b0, 32'h123452B7};
    v[6] = mk(0, 7'h33, 3, 1, 2, 0, 0, 0);              e[6] = {1'b1, 32'h0};
    v[7] = mk(1, 7'h13, 3, 1, 2, 0, 0, 0);              e[7] = {1'b1, 32'h0};
    v[8] = mk(7, 7'h33, 3, 1, 2, 0, 0, 0);              e[8] = {1'b1, 32'h0};
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      drive(v[i], 1'b1, 1'b0);
      @(posedge clk);
      exp_count++;
      @(negedge clk);
      drive(v[i], 1'b0, 1'b0);
      n_tests++; if (bus.o_valid !== 1'b1) begin n_fail++; $display("FAIL vec%0d_o_valid got %b want 1", i, bus.o_valid); end
      n_tests++; if ({bus.o_err, bus.o_instruction} !== e[i]) begin n_fail++; $display("FAIL vec%0d_word got %b/%h want %b/%h", i, bus.o_err, bus.o_instruction, e[i][32], e[i][31:0]); end
      n_tests++; if (bus.o_count !== exp_count) begin n_fail++; $display("FAIL vec%0d_o_count got %0d want %0d", i, bus.o_count, exp_count); end
      bus.i_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.i_ready = 1'b0;
      n_tests++; if (bus.o_valid !== 1'b0 || bus.o_instruction !== 32'h0) begin n_fail++; $display("FAIL vec%0d_drain got %b/%h want 0/0", i, bus.o_valid, bus.o_instruction); end
    end
  endtask

  task automatic test_back_to_back;
    bundle_t a, b, c;
    a = mk(2, 7'h13, 1, 0, 0, 0, 0, 5);
    b = mk(3, 7'h23, 0, 1, 2, 2, 0, 8);
    c = mk(5, 7'h37, 5, 0, 0, 0, 0, 32'h12345000);
    @(negedge clk);
    n_tests++; if (bus.o_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready0 got %b want 1", bus.o_ready); end
    drive(a, 1'b1, 1'b0);
    @(posedge clk); exp_count++;
    @(negedge clk);
    n_tests++; if (bus.o_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready1 got %b want 1", bus.o_ready); end
    drive(b, 1'b1, 1'b0);
    @(posedge clk); exp_count++;
    @(negedge clk);
    n_tests++; if (bus.o_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_full_ready got %b want 0", bus.o_ready); end
    drive(c, 1'b1, 1'b0);
    @(posedge clk);
    @(negedge clk);
    n_tests++; if (bus.o_count !== exp_count) begin n_fail++; $display("FAIL b2b_full_count got %0d want %0d", bus.o_count, exp_count); end
    n_tests++; if (bus.o_instruction !== 32'h00500093) begin n_fail++; $display("FAIL b2b_head_a got %h want 00500093", bus.o_instruction); end
    drive(c, 1'b1, 1'b1);
    @(posedge clk);
    @(negedge clk);
    n_tests++; if (bus.o_instruction !== 32'h0020A423 || bus.o_count !== exp_count) begin n_fail++; $display("FAIL b2b_head_b got %h cnt %0d want 0020A423 cnt %0d", bus.o_instruction, bus.o_count, exp_count); end
    n_tests++; if (bus.o_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_after_pop got %b want 1", bus.o_ready); end
    drive(c, 1'b1, 1'b1);
    @(posedge clk); exp_count++;
    @(negedge clk);
    n_tests++; if (bus.o_valid !== 1'b1 || bus.o_ready !== 1'b1 || bus.o_instruction !== 32'h123452B7) begin n_fail++; $display("FAIL b2b_pushpop got v%b r%b %h want v1 r1 123452B7", bus.o_valid, bus.o_ready, bus.o_instruction); end
    n_tests++; if (bus.o_count !== exp_count) begin n_fail++; $display("FAIL b2b_pushpop_count got %0d want %0d", bus.o_count, exp_count); end
    drive(c, 1'b0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    n_tests++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_empty got %b want 0", bus.o_valid); end
    bus.i_ready = 1'b0;
  endtask

  task automatic test_clk_en;
    bundle_t a, b;
    a = mk(1, 7'h33, 3, 1, 2, 0, 0, 0);
    b = mk(2, 7'h13, 1, 0, 0, 0, 0, 5);
    @(negedge clk);
    drive(a, 1'b1, 1'b0);
    @(posedge clk); exp_count++;
    @(negedge clk);
    clk_en = 1'b0;
    drive(b, 1'b1, 1'b1);
    #1;
    n_tests++; if (bus.o_ready !== 1'b0 || bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL clken_gated got r%b v%b want r0 v0", bus.o_ready, bus.o_valid); end
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++; if (bus.o_count !== exp_count) begin n_fail++; $display("FAIL clken_count got %0d want %0d", bus.o_count, exp_count); end
    clk_en = 1'b1;
    drive(b, 1'b0, 1'b0);
    #1;
    n_tests++; if (bus.o_valid !== 1'b1 || bus.o_instruction !== 32'h002081B3) begin n_fail++; $display("FAIL clken_head got v%b %h want v1 002081B3", bus.o_valid, bus.o_instruction); end
    bus.i_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.i_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    drive(mk(1, 7'h33, 3, 1, 2, 0, 0, 0), 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_tests++; if (bus.o_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre got %b want 1", bus.o_valid); end
    rst = 1'b1;
    bus.i_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_tests++; if (bus.o_valid !== 1'b0 || bus.o_count !== 16'h0) begin n_fail++; $display("FAIL rstmid got v%b cnt %0d want v0 cnt 0", bus.o_valid, bus.o_count); end
    rst = 1'b0;
    exp_count = 16'h0;
    #1;
    n_tests++; if (bus.o_ready !== 1'b1 || bus.o_instruction !== 32'h0) begin n_fail++; $display("FAIL rstmid_post got r%b %h want r1 0", bus.o_ready, bus.o_instruction); end
  endtask

  task automatic test_range;
    logic [32:0] e;
`ifdef ENCODE_RANGE_CHECK_EN
    e = {1'b1, 32'h0};
`else
    e = {1'b0, 32'h00000093};
`endif
    @(negedge clk);
    drive(mk(2, 7'h13, 1, 0, 0, 0, 0, 32'h1000), 1'b1, 1'b0);
    @(posedge clk); exp_count++;
    @(negedge clk);
    bus.i_valid = 1'b0;
    n_tests++; if ({bus.o_err, bus.o_instruction} !== e) begin n_fail++; $display("FAIL range_i_imm got %b/%h want %b/%h", bus.o_err, bus.o_instruction, e[32], e[31:0]); end
    bus.i_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.i_ready = 1'b0;
  endtask

  task automatic test_random;
    logic [32:0] sb[$];
    logic [32:0] e, head;
    bundle_t b;
    logic v, r, push, pop;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      head = sb.size() > 0 ? sb[0] : 33'h0;
      n_tests++; if (bus.o_valid !== (sb.size() > 0)) begin n_fail++; $display("FAIL rnd%0d_o_valid got %b want %b", cyc, bus.o_valid, sb.size() > 0); end
      n_tests++; if (bus.o_ready !== (sb.size() < DEPTH)) begin n_fail++; $display("FAIL rnd%0d_o_ready got %b want %b", cyc, bus.o_ready, sb.size() < DEPTH); end
      n_tests++; if ({bus.o_err, bus.o_instruction} !== head) begin n_fail++; $display("FAIL rnd%0d_word got %b/%h want %b/%h", cyc, bus.o_err, bus.o_instruction, head[32], head[31:0]); end
      n_tests++; if (bus.o_count !== exp_count) begin n_fail++; $display("FAIL rnd%0d_o_count got %0d want %0d", cyc, bus.o_count, exp_count); end
      gen(b, e);
      v = $urandom_range(0, 3) != 0;
      r = $urandom_range(0, 2) != 0;
      drive(b, v, r);
      push = v && sb.size() < DEPTH;
      pop = r && sb.size() > 0;
      @(posedge clk);
      if (pop) void'(sb.pop_front());
      if (push) begin sb.push_back(e); exp_count++; end
    end
    @(negedge clk);
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    repeat (DEPTH) @(posedge clk);
    @(negedge clk);
    bus.i_ready = 1'b0;
    n_tests++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL rnd_drain got %b want 0", bus.o_valid); end
  endtask

  initial begin
    test_reset;
    test_vectors;
    test_back_to_back;
    test_clk_en;
    test_range;
    test_random;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
